// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - controller register map, command bits, states and error codes
package i2c_seq_pkg;

  localparam logic [3:0] REG_STS0 = 4'h0;
  localparam logic [3:0] REG_STS1 = 4'h1;
  localparam logic [3:0] REG_ADDR = 4'h2;
  localparam logic [3:0] REG_CMD  = 4'h3;
  localparam logic [3:0] REG_DATA = 4'h4;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_WRITE = 8'h04;
  localparam logic [7:0] CMD_STOP  = 8'h10;

  localparam int STS0_BUSY = 0;
  localparam int STS0_NACK = 3;
  localparam int STS1_RXE  = 6;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    IDLE, LOAD, WB_ISSUE, WB_WAIT, POLL_START, POLL_DONE,
    CHECK, FIFO_STS, FIFO_DATA, ABORT, RESP
  } state_e;

  // Which kind of access WB_ISSUE launches and where WB_WAIT hands the result.
  typedef enum logic [2:0] {
    PH_CMD, PH_POLL_S, PH_POLL_D, PH_FIFO_S, PH_FIFO_D, PH_ABORT
  } phase_e;

endpackage

// File: rtl/i2c_wb_access.sv
// rtl/i2c_wb_access.sv - one Wishbone read or write with strobe, hold and timeout
module i2c_wb_access #(
  parameter int WB_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [3:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic       timeout_o,
  output logic [7:0] rdata_o,
  output logic       wb_read_o,
  output logic       wb_write_o,
  output logic [3:0] wb_address_o,
  output logic [7:0] wb_data_out_o,
  input  logic [7:0] wb_data_in_i,
  input  logic       wb_data_in_valid_i,
  input  logic       wb_done_i
);

  localparam int CW = $clog2(WB_TIMEOUT + 1);

  logic          active_q;
  logic          we_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          timeout_q;
  logic [7:0]    rdata_q;
  logic          wb_read_q;
  logic          wb_write_q;
  logic [3:0]    wb_address_q;
  logic [7:0]    wb_data_out_q;

  // active_q rises together with the strobe, so a same-cycle wb_done is caught.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q      <= 1'b0;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      rdata_q       <= '0;
      wb_read_q     <= 1'b0;
      wb_write_q    <= 1'b0;
      wb_address_q  <= '0;
      wb_data_out_q <= '0;
    end else begin
      wb_read_q  <= 1'b0;
      wb_write_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      if (!active_q) begin
        if (start_i) begin
          active_q      <= 1'b1;
          we_q          <= we_i;
          wb_read_q     <= !we_i;
          wb_write_q    <= we_i;
          wb_address_q  <= addr_i;
          wb_data_out_q <= wdata_i;
          cnt_q         <= '0;
        end
      end else if (wb_done_i && (we_q || wb_data_in_valid_i)) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
        if (!we_q) rdata_q <= wb_data_in_i;
      end else if (cnt_q == CW'(WB_TIMEOUT)) begin
        active_q  <= 1'b0;
        timeout_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign rdata_o       = rdata_q;
  assign wb_read_o     = wb_read_q;
  assign wb_write_o    = wb_write_q;
  assign wb_address_o  = wb_address_q;
  assign wb_data_out_o = wb_data_out_q;

endmodule

// File: rtl/i2c_reg_seq.sv
// rtl/i2c_reg_seq.sv - register read/write request to I2C controller WB command sequencer
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'h1A,
  parameter int         REG_AW       = 7,
  parameter int         REG_DW       = 9,
  parameter bit         RD_LSB_FIRST = 1'b1,
  parameter int         MAX_RETRY    = 2,
  parameter int         POLL_LIMIT   = 256,
  parameter int         WB_TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [REG_AW-1:0] req_addr,
  input  logic [REG_DW-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [REG_DW-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              busy,
  output logic              wb_read,
  output logic              wb_write,
  output logic [3:0]        wb_address,
  output logic [7:0]        wb_data_out,
  input  logic [7:0]        wb_data_in,
  input  logic              wb_data_in_valid,
  input  logic              wb_done
);

  localparam int FW  = REG_AW + REG_DW;
  localparam int NB  = FW / 8;
  localparam int AB  = (REG_AW + 7) / 8;
  localparam int RB  = (REG_DW + 7) / 8;
  localparam int AW8 = RB * 8;
  localparam int PW  = $clog2(POLL_LIMIT + 1);
  localparam int RW  = $clog2(MAX_RETRY + 2);

  state_e            state_q;
  phase_e            phase_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [REG_DW-1:0] rsp_rdata_q;
  logic [1:0]        rsp_err_q;
  logic [1:0]        err_q;
  logic [FW-1:0]     frame_q;
  logic              wr_q;
  logic [RW-1:0]     retry_q;
  logic [3:0]        idx_q;
  logic [PW-1:0]     poll_q;
  logic [2:0]        rb_q;
  logic [AW8-1:0]    acc_q;
  logic              acc_start_q;
  logic              acc_we_q;
  logic [3:0]        acc_addr_q;
  logic [7:0]        acc_wdata_q;

  logic              acc_done;
  logic              acc_timeout;
  logic [7:0]        acc_rdata;
  logic              iss_we;
  logic [3:0]        iss_addr;
  logic [7:0]        iss_wdata;
  logic              cmd_last;
  logic              poll_hit;
  int                cmd_k;
  int                cmd_nd;

  i2c_wb_access #(.WB_TIMEOUT(WB_TIMEOUT)) u_access (
    .clk                (clk),
    .reset              (reset),
    .start_i            (acc_start_q),
    .we_i               (acc_we_q),
    .addr_i             (acc_addr_q),
    .wdata_i            (acc_wdata_q),
    .done_o             (acc_done),
    .timeout_o          (acc_timeout),
    .rdata_o            (acc_rdata),
    .wb_read_o          (wb_read),
    .wb_write_o         (wb_write),
    .wb_address_o       (wb_address),
    .wb_data_out_o      (wb_data_out),
    .wb_data_in_i       (wb_data_in),
    .wb_data_in_valid_i (wb_data_in_valid),
    .wb_done_i          (wb_done)
  );

  // idx_q walks the command list: ADDR, data bytes, START|WRITE, [START|READ, READs], STOP.
  always_comb begin
    cmd_k     = int'(idx_q);
    cmd_nd    = wr_q ? NB : AB;
    iss_we    = 1'b0;
    iss_addr  = REG_STS0;
    iss_wdata = 8'h00;
    cmd_last  = 1'b0;
    case (phase_q)
      PH_CMD: begin
        iss_we = 1'b1;
        if (cmd_k == 0) begin
          iss_addr  = REG_ADDR;
          iss_wdata = {1'b0, DEV_ADDR};
        end else if (cmd_k <= cmd_nd) begin
          iss_addr  = REG_DATA;
          iss_wdata = 8'(frame_q >> (8 * (NB - cmd_k)));
        end else if (cmd_k == cmd_nd + 1) begin
          iss_addr  = REG_CMD;
          iss_wdata = CMD_START | CMD_WRITE;
        end else if (!wr_q && cmd_k == cmd_nd + 2) begin
          iss_addr  = REG_CMD;
          iss_wdata = CMD_START | CMD_READ;
        end else if (!wr_q && cmd_k < cmd_nd + 2 + RB) begin
          iss_addr  = REG_CMD;
          iss_wdata = CMD_READ;
        end else begin
          iss_addr  = REG_CMD;
          iss_wdata = CMD_STOP;
          cmd_last  = 1'b1;
        end
      end
      PH_FIFO_S: iss_addr = REG_STS1;
      PH_FIFO_D: iss_addr = REG_DATA;
      PH_ABORT: begin
        iss_we    = 1'b1;
        iss_addr  = REG_CMD;
        iss_wdata = CMD_STOP;
      end
      default: iss_addr = REG_STS0;
    endcase
  end

  assign poll_hit = (poll_q == PW'(POLL_LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      phase_q     <= PH_CMD;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
      err_q       <= ERR_OK;
      frame_q     <= '0;
      wr_q        <= 1'b0;
      retry_q     <= '0;
      idx_q       <= '0;
      poll_q      <= '0;
      rb_q        <= '0;
      acc_q       <= '0;
      acc_start_q <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
    end else begin
      acc_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            wr_q        <= req_wr;
            frame_q     <= req_wr ? {req_addr, req_wdata} : {req_addr, {REG_DW{1'b0}}};
            retry_q     <= '0;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          idx_q   <= '0;
          poll_q  <= '0;
          rb_q    <= '0;
          acc_q   <= '0;
          phase_q <= PH_CMD;
          state_q <= WB_ISSUE;
        end
        WB_ISSUE: begin
          acc_start_q <= 1'b1;
          acc_we_q    <= iss_we;
          acc_addr_q  <= iss_addr;
          acc_wdata_q <= iss_wdata;
          state_q     <= WB_WAIT;
        end
        WB_WAIT: begin
          if (acc_timeout) begin
            state_q <= (phase_q == PH_ABORT) ? RESP : ABORT;
          end else if (acc_done) begin
            case (phase_q)
              PH_CMD: begin
                if (cmd_last) begin
                  phase_q <= PH_POLL_S;
                  poll_q  <= '0;
                end else begin
                  idx_q <= idx_q + 4'd1;
                end
                state_q <= WB_ISSUE;
              end
              PH_POLL_S: state_q <= POLL_START;
              PH_POLL_D: state_q <= POLL_DONE;
              PH_FIFO_S: state_q <= FIFO_STS;
              PH_FIFO_D: state_q <= FIFO_DATA;
              default:   state_q <= RESP;
            endcase
          end
        end
        POLL_START: begin
          if (acc_rdata[STS0_BUSY]) begin
            phase_q <= PH_POLL_D;
            poll_q  <= '0;
            state_q <= WB_ISSUE;
          end else if (poll_hit) begin
            state_q <= ABORT;
          end else begin
            poll_q  <= poll_q + PW'(1);
            state_q <= WB_ISSUE;
          end
        end
        POLL_DONE: begin
          if (!acc_rdata[STS0_BUSY]) begin
            state_q <= CHECK;
          end else if (poll_hit) begin
            state_q <= ABORT;
          end else begin
            poll_q  <= poll_q + PW'(1);
            state_q <= WB_ISSUE;
          end
        end
        CHECK: begin
          if (acc_rdata[STS0_NACK]) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_q <= retry_q + RW'(1);
              state_q <= LOAD;
            end else begin
              err_q   <= ERR_NACK;
              state_q <= RESP;
            end
          end else if (wr_q) begin
            err_q   <= ERR_OK;
            state_q <= RESP;
          end else begin
            phase_q <= PH_FIFO_S;
            poll_q  <= '0;
            rb_q    <= '0;
            state_q <= WB_ISSUE;
          end
        end
        FIFO_STS: begin
          if (!acc_rdata[STS1_RXE]) begin
            phase_q <= PH_FIFO_D;
            state_q <= WB_ISSUE;
          end else if (poll_hit) begin
            state_q <= ABORT;
          end else begin
            poll_q  <= poll_q + PW'(1);
            state_q <= WB_ISSUE;
          end
        end
        FIFO_DATA: begin
          if (RD_LSB_FIRST) acc_q <= acc_q | (AW8'(acc_rdata) << {rb_q, 3'b000});
          else              acc_q <= (acc_q << 8) | AW8'(acc_rdata);
          if (rb_q == 3'(RB - 1)) begin
            err_q   <= ERR_OK;
            state_q <= RESP;
          end else begin
            rb_q    <= rb_q + 3'd1;
            phase_q <= PH_FIFO_S;
            poll_q  <= '0;
            state_q <= WB_ISSUE;
          end
        end
        ABORT: begin
          err_q   <= ERR_TIMEOUT;
          phase_q <= PH_ABORT;
          state_q <= WB_ISSUE;
        end
        RESP: begin
          rsp_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          rsp_err_q   <= err_q;
          rsp_rdata_q <= (err_q == ERR_OK && !wr_q) ? acc_q[REG_DW-1:0] : '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb/tb_i2c_reg_seq.sv - directed bench with a behavioural WB I2C controller model
module tb_i2c_reg_seq;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [6:0] req_addr;
  logic [8:0] req_wdata;
  logic       rsp_valid;
  logic [8:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       busy;
  logic       wb_read;
  logic       wb_write;
  logic [3:0] wb_address;
  logic [7:0] wb_data_out;
  logic [7:0] wb_data_in;
  logic       wb_data_in_valid;
  logic       wb_done;

  i2c_reg_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .wb_read(wb_read), .wb_write(wb_write), .wb_address(wb_address),
    .wb_data_out(wb_data_out), .wb_data_in(wb_data_in),
    .wb_data_in_valid(wb_data_in_valid), .wb_done(wb_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model configuration (driven by the stimulus block only)
  logic       model_clr;
  logic       imm;
  logic       withhold;
  logic       stuck;
  int         nack_mode;
  logic [7:0] fifo_mem [0:3];

  // Controller model state (driven by the model block only)
  logic [11:0] wl [0:63];
  int          wl_n;
  int          addr_cnt;
  int          sts0_reads;
  int          busy_left;
  logic [1:0]  fifo_rd;
  logic        empty_flag;
  logic        done_q;
  logic        cur_we;
  logic        sts1_seen;
  logic        nack_now;
  logic [7:0]  rd_byte;

  assign nack_now = (nack_mode == 1) || (nack_mode == 2 && addr_cnt == 1);
  assign wb_done = !withhold && (done_q || (imm && (wb_read || wb_write)));
  assign wb_data_in_valid = wb_done;
  assign wb_data_in = rd_byte;

  always_comb begin
    rd_byte = 8'h00;
    case (wb_address)
      4'h0: rd_byte = {4'b0, nack_now, 2'b0, (stuck || busy_left > 0)};
      4'h1: rd_byte = {1'b0, empty_flag, 6'b0};
      4'h4: rd_byte = fifo_mem[fifo_rd];
      default: rd_byte = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (model_clr) begin
      wl_n <= 0; addr_cnt <= 0; sts0_reads <= 0; busy_left <= 0;
      fifo_rd <= 2'd0; empty_flag <= 1'b1; done_q <= 1'b0; cur_we <= 1'b0; sts1_seen <= 1'b0;
    end else begin
      done_q <= (wb_read || wb_write) && !imm;
      if (wb_read || wb_write) cur_we <= wb_write;
      if (wb_write) begin
        if (wl_n < 64) wl[wl_n] <= {wb_address, wb_data_out};
        wl_n <= wl_n + 1;
        if (wb_address == 4'h2) addr_cnt <= addr_cnt + 1;
        if (wb_address == 4'h3 && wb_data_out[4]) busy_left <= 1;
      end
      if (wb_done && !((wb_read || wb_write) ? wb_write : cur_we)) begin
        case (wb_address)
          4'h0: begin
            sts0_reads <= sts0_reads + 1;
            if (busy_left > 0) busy_left <= busy_left - 1;
          end
          4'h1: begin
            empty_flag <= !empty_flag;
            sts1_seen  <= 1'b1;
          end
          4'h4: fifo_rd <= fifo_rd + 2'd1;
          default: ;
        endcase
      end
    end
  end

  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    @(negedge clk); model_clr = 1'b1;
    @(negedge clk); model_clr = 1'b0;
  endtask

  task automatic send(input logic wr, input logic [6:0] a, input logic [8:0] d);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!req_ready) chk("req_ready_wait", 0, 1);
    req_wr = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output logic [8:0] rd, output logic [1:0] er, output int cyc);
    logic got;
    got = 1'b0; rd = '0; er = '0; cyc = 0;
    while (!got && cyc < bound) begin
      @(negedge clk); cyc++;
      if (rsp_valid) begin
        got = 1'b1; rd = rsp_rdata; er = rsp_err;
      end
    end
    if (!got) chk("rsp_wait", 0, 1);
  endtask

  logic [8:0]  rd;
  logic [1:0]  er;
  int          cyc;
  logic [27:0] outs;

  always_comb outs = {req_ready, busy, rsp_valid, rsp_rdata, rsp_err, wb_read, wb_write, wb_address, wb_data_out};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    model_clr = 1'b1; imm = 1'b0; withhold = 1'b0; stuck = 1'b0; nack_mode = 0;
    fifo_mem[0] = 8'h34; fifo_mem[1] = 8'h01; fifo_mem[2] = 8'h00; fifo_mem[3] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(outs), 0);
    reset = 1'b1; model_clr = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 1);

    // Write 0x04 <- 0x1A5
    send(1'b1, 7'h04, 9'h1A5);
    chk("busy_after_accept", 32'(busy), 1);
    chk("ready_after_accept", 32'(req_ready), 0);
    wait_rsp(400, rd, er, cyc);
    chk("wr_busy_at_rsp", 32'(busy), 0);
    chk("wr_err", 32'(er), 0);
    chk("wr_rdata", 32'(rd), 0);
    chk("wr_nwrites", 32'(wl_n), 5);
    chk("wr_w0", 32'(wl[0]), 32'h21A);
    chk("wr_w1", 32'(wl[1]), 32'h409);
    chk("wr_w2", 32'(wl[2]), 32'h4A5);
    chk("wr_w3", 32'(wl[3]), 32'h305);
    chk("wr_w4", 32'(wl[4]), 32'h310);
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp_valid), 0);

    // Read 0x07, FIFO 0x34 then 0x01, wb_done in the strobe cycle
    clear_model(); imm = 1'b1;
    send(1'b0, 7'h07, 9'h000);
    wait_rsp(600, rd, er, cyc);
    chk("rd_err", 32'(er), 0);
    chk("rd_rdata", 32'(rd), 32'h134);
    chk("rd_nwrites", 32'(wl_n), 6);
    chk("rd_w1", 32'(wl[1]), 32'h40E);
    chk("rd_w2", 32'(wl[2]), 32'h305);
    chk("rd_w3", 32'(wl[3]), 32'h303);
    chk("rd_w4", 32'(wl[4]), 32'h302);
    chk("rd_w5", 32'(wl[5]), 32'h310);
    imm = 1'b0;

    // Persistent NACK on a read
    clear_model(); nack_mode = 1;
    send(1'b0, 7'h10, 9'h000);
    wait_rsp(1500, rd, er, cyc);
    chk("nack_err", 32'(er), 1);
    chk("nack_rdata", 32'(rd), 0);
    chk("nack_addr_writes", 32'(addr_cnt), 3);

    // NACK on the first attempt only
    clear_model(); nack_mode = 2;
    send(1'b1, 7'h7F, 9'h0FF);
    wait_rsp(1500, rd, er, cyc);
    chk("retry_err", 32'(er), 0);
    chk("retry_addr_writes", 32'(addr_cnt), 2);
    chk("retry_nwrites", 32'(wl_n), 10);
    nack_mode = 0;

    // STS0 busy stuck
    clear_model(); stuck = 1'b1;
    send(1'b1, 7'h01, 9'h002);
    wait_rsp(5000, rd, er, cyc);
    chk("stuck_err", 32'(er), 2);
    chk("stuck_sts0_reads", 32'(sts0_reads), 257);
    chk("stuck_nwrites", 32'(wl_n), 6);
    chk("stuck_stop", 32'(wl[5]), 32'h310);
    stuck = 1'b0;

    // wb_done withheld
    clear_model(); withhold = 1'b1;
    send(1'b1, 7'h02, 9'h003);
    wait_rsp(1000, rd, er, cyc);
    chk("wbto_err", 32'(er), 2);
    chk("wbto_nwrites", 32'(wl_n), 2);
    chk("wbto_stop", 32'(wl[1]), 32'h310);
    chk("wbto_min_cycles", 32'(cyc >= 130), 1);
    withhold = 1'b0;

    // Reset during the FIFO read, then a normal write
    clear_model();
    send(1'b0, 7'h05, 9'h000);
    cyc = 0;
    while (!sts1_seen && cyc < 600) begin
      @(negedge clk); cyc++;
    end
    chk("fifo_reached", 32'(sts1_seen), 1);
    reset = 1'b0; model_clr = 1'b1;
    #1;
    chk("midreset_outputs", 32'(outs), 0);
    @(negedge clk);
    @(negedge clk);
    chk("midreset_hold", 32'(outs), 0);
    reset = 1'b1; model_clr = 1'b0;
    @(negedge clk);
    chk("midreset_ready", 32'(req_ready), 1);
    send(1'b1, 7'h04, 9'h1A5);
    wait_rsp(400, rd, er, cyc);
    chk("post_err", 32'(er), 0);
    chk("post_nwrites", 32'(wl_n), 5);
    chk("post_w2", 32'(wl[2]), 32'h4A5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
